// File: rtl/psg_seq_pkg.sv
// Shared types and constants for the PSG command sequencer: FSM states,
// command opcodes and PSG register indices for drivers and benches.
package psg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_WAIT    = 3'd4
    } state_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_WAIT  = 1'b1;

    localparam logic [3:0] TONE_A_FINE   = 4'h0;
    localparam logic [3:0] TONE_A_COARSE = 4'h1;
    localparam logic [3:0] TONE_B_FINE   = 4'h2;
    localparam logic [3:0] TONE_B_COARSE = 4'h3;
    localparam logic [3:0] TONE_C_FINE   = 4'h4;
    localparam logic [3:0] TONE_C_COARSE = 4'h5;
    localparam logic [3:0] NOISE_PERIOD  = 4'h6;
    localparam logic [3:0] MIXER         = 4'h7;
    localparam logic [3:0] AMP_A         = 4'h8;
    localparam logic [3:0] AMP_B         = 4'h9;
    localparam logic [3:0] AMP_C         = 4'ha;
    localparam logic [3:0] ENV_FINE      = 4'hb;
    localparam logic [3:0] ENV_COARSE    = 4'hc;
    localparam logic [3:0] ENV_SHAPE     = 4'hd;

endpackage

// File: rtl/psg_seq_if.sv
// Command stream from the CPU-side bus slave into the sequencer.
// Handshake: a command transfers on a clk edge where cmd_valid & cmd_ready;
// the master holds op/addr/data stable while cmd_valid is high and ready is low.
interface psg_seq_if #(parameter int WAIT_W = 16) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [3:0]        cmd_addr;
    logic [WAIT_W-1:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/psg_seq_fifo.sv
// Synchronous command FIFO with flush; head is read from the storage flops,
// so an entry is visible only the cycle after it is written.
module psg_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full & ~flush;
        do_pop   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/psg_seq.sv
// PSG command sequencer: queues register writes and sample-tick waits, then
// replays writes onto the PSG register port with a full-width strobe each.
module psg_seq
    import psg_seq_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int WAIT_W        = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    psg_seq_if.slave               cmd,
    input  logic                   sample,
    input  logic                   enable,
    input  logic                   flush,
    output logic [3:0]             psg_addr,
    output logic [7:0]             psg_din,
    output logic                   psg_cs_n,
    output logic                   psg_wr_n,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output state_e                 dbg_state
);
    localparam int FW  = 1 + 4 + WAIT_W;
    localparam int SCW = $clog2(STROBE_CYCLES + 1);

    state_e            state_q, state_d;
    logic [SCW-1:0]    strb_cnt_q, strb_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]        addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              strobe_n_q, strobe_n_d;

    logic              fifo_full, fifo_empty, push, pop;
    logic [FW-1:0]     head;
    logic              head_op;
    logic [3:0]        head_addr;
    logic [WAIT_W-1:0] head_data;

    assign cmd.cmd_ready = ~fifo_full & ~flush;
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign {head_op, head_addr, head_data} = head;

    psg_seq_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({cmd.cmd_op, cmd.cmd_addr, cmd.cmd_data}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            strb_cnt_q <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            strobe_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            strb_cnt_q <= strb_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            strobe_n_q <= strobe_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        strb_cnt_d = strb_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A zero-length wait is popped and dropped without leaving IDLE.
                if (enable && !fifo_empty && !flush) begin
                    pop = 1'b1;
                    if (head_op == OP_WRITE) begin
                        state_d = ST_SETUP;
                    end else if (head_data != '0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = head_data;
                    end
                end
            end
            ST_SETUP: begin
                state_d    = ST_STROBE;
                strb_cnt_d = SCW'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (strb_cnt_q == '0) state_d = ST_RECOVER;
                else                  strb_cnt_d = strb_cnt_q - 1'b1;
            end
            ST_RECOVER: state_d = ST_IDLE;
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                    if (wait_cnt_q == WAIT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobe flop follows the next state so it is low exactly while in STROBE.
    always_comb begin
        addr_d     = addr_q;
        din_d      = din_q;
        strobe_n_d = (state_d != ST_STROBE);
        if (pop && head_op == OP_WRITE) begin
            addr_d = head_addr;
            din_d  = head_data[7:0];
        end
    end

    assign psg_addr  = addr_q;
    assign psg_din   = din_q;
    assign psg_cs_n  = strobe_n_q;
    assign psg_wr_n  = strobe_n_q;
    assign busy      = (state_q != ST_IDLE) || (level != '0);
    assign dbg_state = state_q;
endmodule

// File: doc/psg_seq.md
# psg_seq

Command sequencer for the three-channel PSG sound core. Accepts register-write and wait commands from the CPU-side bus over a valid/ready stream and buffers them in a small FIFO. Replays them onto the PSG's asynchronous-style register port with correct strobe timing, and paces playback in PSG sample ticks. It sits between the bus slave and the PSG, so music data can be queued without the CPU polling.

## Interface
Parameters:
- DEPTH, 8: command FIFO depth; power of two, at least 2.
- WAIT_W, 16: width of the wait count.
- STROBE_CYCLES, 2: number of clk cycles that psg_cs_n/psg_wr_n are held low per write; at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full & !flush.
- cmd_op  in  1  0 = register write, 1 = wait.
- cmd_addr  in  4  PSG register index; ignored for wait.
- cmd_data  in  WAIT_W  write: [7:0] register value; wait: tick count.
- sample  in  1  one-cycle PSG sample tick.
- enable  in  1  permits popping the next command.
- flush  in  1  one-cycle pulse; discards queued commands.
- psg_addr  out  4  to PSG addr.
- psg_din  out  8  to PSG din.
- psg_cs_n  out  1  to PSG cs_n.
- psg_wr_n  out  1  to PSG wr_n.
- busy  out  1  state != IDLE or level != 0.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: psg_cs_n=1, psg_wr_n=1, psg_addr=0, psg_din=0, level=0, busy=0, state=IDLE, cmd_ready=1.
- Push: on cmd_valid & cmd_ready, the entry {op, addr, data} is written to the FIFO. A push while full is impossible because ready is low.
- FSM states: IDLE, SETUP, STROBE, RECOVER, WAIT.
- IDLE: if enable & !empty & !flush, pop the head entry into holding registers.
  - Write → SETUP.
  - Wait with count>0 → WAIT.
  - Wait with count=0 → stays IDLE; this is a no-op that consumes a pop slot.
- SETUP, 1 cycle: psg_addr/psg_din driven from the holding registers; strobes high.
- STROBE, STROBE_CYCLES cycles: psg_cs_n=psg_wr_n=0; addr/din stable.
- RECOVER, 1 cycle: strobes high; addr/din still held. This guarantees a strobe edge, so consecutive writes to 4'hd each restart the envelope. Then → IDLE.
- WAIT: the counter is loaded at pop. It decrements on each sample pulse; on a sample pulse with count==1 → IDLE. A sample pulse coincident with the pop cycle is not counted.
- psg_addr/psg_din retain their last values in IDLE and WAIT.
- enable=0 only blocks pops. A write in progress completes, and WAIT keeps counting.
- Flush:
  - Clears the FIFO (level=0 next cycle).
  - WAIT → IDLE immediately.
  - A write in SETUP/STROBE/RECOVER completes unchanged; strobes are never truncated.
  - Blocks pop and push in the flush cycle.
- Simultaneous push and pop: level unchanged; both take effect.

## Timing
- Write latency, pop cycle to first strobe-low cycle: 2 clk.
- Write occupancy: STROBE_CYCLES+3 cycles per command (IDLE/pop, SETUP, STROBE×S, RECOVER).
- Back-to-back writes: one per STROBE_CYCLES+3 cycles (5 at the default).
- FIFO has no fall-through: an entry pushed at cycle n is poppable at cycle n+1 at the earliest.
- Wait of N ends on the Nth counted sample pulse; the next pop occurs in the following cycle.
- All outputs are registered except cmd_ready and busy, which are combinational from registered state.

## Structure
- Package psg_seq_pkg holds:
  - the state enum;
  - OP_WRITE/OP_WAIT constants;
  - PSG register index constants (ENV_SHAPE = 4'hd, MIXER = 4'h7, etc.) for benches and drivers.
- Sub-module psg_seq_fifo: a synchronous FIFO with width 1+4+WAIT_W and depth DEPTH. It provides push, pop, flush, full, empty and level, with registered head output.
- Top level: FSM, holding registers, wait counter, output registers.

## Test plan
- Single write {op=0, addr=4'h8, data=8'h1F} after reset → psg_addr=8 and psg_din=8'h1F from SETUP; cs_n/wr_n low for exactly 2 cycles; busy falls 5 cycles after the pop.
- Two queued writes to 4'hd (8'h0E, 8'h0A) → two separate low strobe pulses separated by at least 1 high cycle; second pop 5 cycles after the first.
- Wait 3 then write addr 0: apply sample pulses every 10 cycles plus one in the pop cycle → the pop-cycle pulse is ignored; the write pops in the cycle after the 3rd counted pulse.
- Push 9 commands with DEPTH=8 and enable=0 → cmd_ready low after 8, level=8; set enable=1 → all 8 play in order, level returns to 0.
- Flush during STROBE with 4 entries queued → the current strobe completes at full width; level=0 next cycle; no further strobes. Flush during WAIT 100 → IDLE next cycle.
- Assert rst mid-STROBE → strobes high and outputs at reset values immediately (asynchronously); level=0; after release, a new write executes normally.
